spike_split: RTL and testbench
==============================

SPIKE_SPLIT -- requirements
Module: spike_split

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the packet width in bits.
REQ-002 Parameter DEPTH, default 4, SHALL set the per-output FIFO depth; it SHALL be a power of two and at least 2.
REQ-003 Parameter DST_BIT, default WIDTH-1, SHALL index the packet bit that selects the output (0 selects A, 1 selects B).
REQ-004 Parameter BC_BIT, default WIDTH-2, SHALL index the packet bit that requests broadcast to both outputs.
REQ-005 The module SHALL have one clock; reset SHALL be synchronous and active-low.
REQ-006 clk  input  1  sole clock; all state updates on the rising edge.
REQ-007 rst_n  input  1  synchronous active-low reset.
REQ-008 in_valid  input  1  the producer offers in_data.
REQ-009 in_data  input  WIDTH  packet from the upstream merge or producer.
REQ-010 in_ready  output  1  the block accepts in_data this cycle.
REQ-011 a_valid  output  1  a_data is valid.
REQ-012 a_data  output  WIDTH  head of FIFO A.
REQ-013 a_ready  input  1  consumer A takes the head this cycle.
REQ-014 b_valid, b_data, b_ready  SHALL mirror a_valid, a_data and a_ready for output B.
REQ-015 a_count, b_count  output  $clog2(DEPTH)+1  occupancy of each FIFO.

Function
REQ-016 A transfer SHALL occur on any edge where valid and ready are both 1, on any channel.
REQ-017 Target set: when in_data[BC_BIT]=1 the target SHALL be {A,B}; otherwise it SHALL be A if in_data[DST_BIT]=0, else B.
REQ-018 in_ready SHALL be 1 only when every target FIFO has a count below DEPTH; it SHALL be computed combinationally from in_data and the registered counts.
REQ-019 A pop on the same edge SHALL NOT free space for that edge's push; there is no full-FIFO bypass.
REQ-020 A broadcast packet SHALL be written to both FIFOs on the same edge or to neither; there are no partial writes.
REQ-021 Packets SHALL be stored unmodified, including the DST and BC bits.
REQ-022 Latency SHALL be exactly 1 cycle: a packet accepted at edge N appears at the FIFO head with valid=1 after edge N when that FIFO was empty.
REQ-023 Throughput SHALL be one input packet per cycle while target space exists.
REQ-024 a_valid SHALL equal (a_count != 0), and a_data SHALL be the oldest unpopped entry of FIFO A; B SHALL behave the same way.
REQ-025 The outputs SHALL be independent: a stalled consumer on A SHALL NOT block traffic that targets only B.
REQ-026 Order SHALL be preserved within each output; no ordering is required between A and B.
REQ-027 A simultaneous push and pop on the same FIFO SHALL leave its count unchanged and advance both pointers.
REQ-028 Read and write pointers SHALL wrap modulo DEPTH, and count SHALL saturate to neither more than DEPTH nor less than 0.
REQ-029 in_ready SHALL be 0 whenever in_valid=0; the producer SHALL ignore it in that case.

Reset
REQ-030 While rst_n=0 at an edge, pointers and counts SHALL clear to 0, a_valid and b_valid SHALL read 0, and in_ready SHALL read 0.
REQ-031 Reset asserted mid-operation SHALL discard all buffered packets; the first push after release SHALL appear at count 1.
REQ-032 FIFO storage SHALL need no reset, and a_data and b_data SHALL be don't-care while valid=0.

Structure
REQ-033 A shared package SHALL hold the default width constant, the DST_BIT and BC_BIT defaults, and a target-set typedef with the values NONE, A, B and BOTH.
REQ-034 A sub-module split_fifo (synchronous, parameterised by WIDTH and DEPTH, with push, pop, head, count, full and empty) SHALL be instantiated twice.
REQ-035 Routing decode and the in_ready logic SHALL live in the top module.

Verification
REQ-036 After reset, push 0x05 (DST=0, BC=0) with a_ready=1: a_valid is 1 with a_data=0x05 one cycle later, and b_valid stays 0.
REQ-037 Push 0xC3 (BC=1): both outputs present 0xC3 after one cycle, and each count is 1 until popped.
REQ-038 With a_ready=0, push DEPTH+1 packets to A: in_ready drops after the DEPTH-th packet, a_count holds at DEPTH, and packets to B are still accepted.
REQ-039 With FIFO A full and B empty, offer a broadcast: in_ready=0 and neither count changes; raising a_ready for one cycle allows acceptance on the following cycle.
REQ-040 Run 1000 random packets with random valid/ready: each output sequence equals the scoreboard-filtered input order, with no loss or duplication and counts never above DEPTH.
REQ-041 Assert rst_n=0 for one cycle with both FIFOs half full: the counts read 0 and the valids read 0 on the next cycle, and subsequent traffic behaves as from a fresh reset.

Source files
------------

// File: rtl/spike_split_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spike_split_pkg
// Purpose  : Shared constants and types for the spike_split router: default
//            packet width, default routing-bit positions, the target-set type
//            and the routing decode helper.
// Ports    : (package - none)
// Revision : 1.0 - initial release
// ============================================================================
package spike_split_pkg;

    localparam int DEFAULT_WIDTH   = 8;
    localparam int DEFAULT_DST_BIT = DEFAULT_WIDTH - 1;
    localparam int DEFAULT_BC_BIT  = DEFAULT_WIDTH - 2;

    // Bit 0 marks output A and bit 1 marks output B. BOTH is therefore the
    // union of the two.
    typedef enum logic [1:0] {
        NONE = 2'b00,
        A    = 2'b01,
        B    = 2'b10,
        BOTH = 2'b11
    } target_e;

    // Broadcast overrides the destination bit. No offer means no target.
    function automatic target_e decode_target(input logic valid,
                                              input logic dst,
                                              input logic bc);
        target_e t;
        if (!valid)   t = NONE;
        else if (bc)  t = BOTH;
        else if (dst) t = B;
        else          t = A;
        return t;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spike_split_fifo.sv
`default_nettype none
// ============================================================================
// Module   : split_fifo
// Purpose  : Synchronous FIFO used once per spike_split output. Storage is
//            not reset. Pointers wrap modulo DEPTH.
// Ports    : clk, rst_n (sync, active-low)
//            push / push_data : write request and payload
//            pop              : consume head
//            head             : oldest entry (don't-care when empty)
//            count            : occupancy 0..DEPTH
//            full / empty     : occupancy flags
// Revision : 1.0 - initial release
// ============================================================================
module split_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    // Flags come from the registered count, so a same-edge pop never makes
    // room for a same-edge push.
    assign do_push = push && !full;
    assign do_pop  = pop  && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule
`default_nettype wire

// File: rtl/spike_split.sv
`default_nettype none
// ============================================================================
// Module   : spike_split
// Purpose  : Routes each input packet to output A, output B or both, based on
//            its destination and broadcast bits. Each output is buffered by
//            its own FIFO, so a stalled consumer on one side does not block
//            the other side.
// Ports    : clk, rst_n (sync, active-low)
//            in_valid / in_data / in_ready : upstream handshake
//            a_valid / a_data / a_ready     : output A handshake
//            b_valid / b_data / b_ready     : output B handshake
//            a_count / b_count              : FIFO occupancies
// Revision : 1.0 - initial release
// ============================================================================
module spike_split
    import spike_split_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int DEPTH   = 4,
    parameter int DST_BIT = WIDTH - 1,
    parameter int BC_BIT  = WIDTH - 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic [WIDTH-1:0]       in_data,
    output logic                   in_ready,
    output logic                   a_valid,
    output logic [WIDTH-1:0]       a_data,
    input  logic                   a_ready,
    output logic                   b_valid,
    output logic [WIDTH-1:0]       b_data,
    input  logic                   b_ready,
    output logic [$clog2(DEPTH):0] a_count,
    output logic [$clog2(DEPTH):0] b_count
);

    target_e tgt;
    logic    want_a, want_b;
    logic    a_full, a_empty, b_full, b_empty;
    logic    push_a, push_b;

    always_comb begin
        tgt = decode_target(in_valid, in_data[DST_BIT], in_data[BC_BIT]);
    end

    assign want_a = (tgt == A) || (tgt == BOTH);
    assign want_b = (tgt == B) || (tgt == BOTH);

    // Ready only when every target has room. This makes a broadcast all or
    // nothing. Ready is held low in reset and when nothing is offered.
    assign in_ready = rst_n && (tgt != NONE)
                      && !(want_a && a_full)
                      && !(want_b && b_full);

    assign push_a = in_ready && want_a;
    assign push_b = in_ready && want_b;

    assign a_valid = !a_empty;
    assign b_valid = !b_empty;

    split_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_a),
        .push_data (in_data),
        .pop       (a_valid && a_ready),
        .head      (a_data),
        .count     (a_count),
        .full      (a_full),
        .empty     (a_empty)
    );

    split_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_b),
        .push_data (in_data),
        .pop       (b_valid && b_ready),
        .head      (b_data),
        .count     (b_count),
        .full      (b_full),
        .empty     (b_empty)
    );

endmodule
`default_nettype wire

// File: tb/tb_spike_split.sv
`default_nettype none
// ============================================================================
// Module   : tb_spike_split
// Purpose  : Self-checking bench for spike_split. It drives directed and
//            random traffic. A queue-based model predicts in_ready, the
//            valids, the counts and the head data on every cycle.
// Ports    : (testbench - none)
// Revision : 1.0 - initial release
// ============================================================================
module tb_spike_split;

    localparam int W  = 8;
    localparam int D  = 4;
    localparam int CW = $clog2(D) + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic [W-1:0]  in_data;
    logic          in_ready;
    logic          a_valid, b_valid;
    logic [W-1:0]  a_data, b_data;
    logic          a_ready, b_ready;
    logic [CW-1:0] a_count, b_count;

    logic [W-1:0]  qa[$];
    logic [W-1:0]  qb[$];
    int            n_checks = 0;
    int            n_fail   = 0;

    spike_split #(.WIDTH(W), .DEPTH(D)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .a_valid  (a_valid),
        .a_data   (a_data),
        .a_ready  (a_ready),
        .b_valid  (b_valid),
        .b_data   (b_data),
        .b_ready  (b_ready),
        .a_count  (a_count),
        .b_count  (b_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Compare the DUT against the model queues. The queue sizes and fronts
    // are the expected counts, valids and heads.
    task automatic check_outputs();
        check("a_valid", a_valid, qa.size() != 0);
        check("b_valid", b_valid, qb.size() != 0);
        check("a_count", a_count, qa.size());
        check("b_count", b_count, qb.size());
        check("a_count_bound", a_count <= D, 1);
        check("b_count_bound", b_count <= D, 1);
        if (qa.size() != 0) check("a_data", a_data, qa[0]);
        if (qb.size() != 0) check("b_data", b_data, qb[0]);
    endtask

    // Runs one clock cycle of traffic. The bench checks the combinational
    // outputs before the edge and then updates the model with what
    // transferred.
    task automatic step(input logic v, input logic [W-1:0] d, input logic ar, input logic br);
        bit to_a, to_b, exp_rdy;
        rst_n    = 1'b1;
        in_valid = v;
        in_data  = d;
        a_ready  = ar;
        b_ready  = br;
        #1;
        to_a    = v && (d[W-2] || !d[W-1]);
        to_b    = v && (d[W-2] ||  d[W-1]);
        exp_rdy = v && (!to_a || qa.size() < D) && (!to_b || qb.size() < D);
        check("in_ready", in_ready, exp_rdy);
        check_outputs();
        @(posedge clk);
        if (ar && qa.size() != 0) void'(qa.pop_front());
        if (br && qb.size() != 0) void'(qb.pop_front());
        if (exp_rdy) begin
            if (to_a) qa.push_back(d);
            if (to_b) qb.push_back(d);
        end
        #1;
    endtask

    // Holds reset for one edge while offering a packet. Afterwards all
    // buffered state is expected to be gone.
    task automatic reset_step();
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_data  = W'($urandom);
        a_ready  = 1'b1;
        b_ready  = 1'b1;
        #1;
        check("in_ready_in_reset", in_ready, 0);
        @(posedge clk);
        qa.delete();
        qb.delete();
        #1;
        check("a_count_reset", a_count, 0);
        check("b_count_reset", b_count, 0);
        check("a_valid_reset", a_valid, 0);
        check("b_valid_reset", b_valid, 0);
        check("in_ready_reset", in_ready, 0);
    endtask

    task automatic drain();
        for (int i = 0; i < 2 * D + 2; i++) step(1'b0, '0, 1'b1, 1'b1);
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        a_ready  = 1'b0;
        b_ready  = 1'b0;
        @(posedge clk);
        #1;
        reset_step();

        // Unicast to A: 1-cycle latency, B untouched
        step(1'b1, 8'h05, 1'b1, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b1);

        // Broadcast: both sides hold 0xC3 with count 1 until popped
        step(1'b1, 8'hC3, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b1);

        // Fill A past DEPTH with its consumer stalled; B still accepts
        for (int i = 0; i <= D; i++) step(1'b1, 8'h10 + 8'(i), 1'b0, 1'b1);
        step(1'b1, 8'h81, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1);

        // Broadcast against a full A: refused, a pop frees room only for the next cycle
        step(1'b1, 8'h40, 1'b0, 1'b0);
        step(1'b1, 8'h40, 1'b1, 1'b0);
        step(1'b1, 8'h40, 1'b0, 1'b0);
        drain();

        // Random traffic
        for (int i = 0; i < 1000; i++)
            step($urandom_range(0, 3) != 0, W'($urandom),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
        drain();

        // Mid-operation reset with both FIFOs half full
        for (int i = 0; i < D / 2; i++) step(1'b1, W'($urandom) | 8'h40, 1'b0, 1'b0);
        reset_step();
        step(1'b1, 8'h22, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++)
            step($urandom_range(0, 1) != 0, W'($urandom),
                 $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
